// File: rtl/axi4_lite_gpu_fbuf_scanout.sv
// Framebuffer scanout: walks the RGB332 framebuffer in raster order and produces
// a timed RGB888 video stream, with integer upscaling and BRAM latency compensation.
module axi4_lite_gpu_fbuf_scanout #(
    parameter int unsigned FRAME_WIDTH_SCALED  = 640,
    parameter int unsigned FRAME_HEIGHT_SCALED = 480,
    parameter int unsigned SCALE               = 1,
    parameter int unsigned H_FP                = 16,
    parameter int unsigned H_SYNC              = 96,
    parameter int unsigned H_BP                = 48,
    parameter int unsigned V_FP                = 10,
    parameter int unsigned V_SYNC              = 2,
    parameter int unsigned V_BP                = 33,
    parameter int unsigned SYNC_ACTIVE_LOW     = 1,
    parameter int unsigned BRAM_LATENCY        = 2,
    parameter int unsigned FBUF_ADDR_WIDTH     = 19,
    parameter int unsigned FBUF_DATA_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fbuf_rst_busy,
    output logic                       fbuf_en_rd,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rdata,
    output logic                       vid_hsync,
    output logic                       vid_vsync,
    output logic                       vid_de,
    output logic [23:0]                vid_rgb,
    output logic                       frame_start
);

    localparam int unsigned H_ACTIVE = FRAME_WIDTH_SCALED * SCALE;
    localparam int unsigned V_ACTIVE = FRAME_HEIGHT_SCALED * SCALE;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned H_TOTAL  = HS_END + H_BP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned V_TOTAL  = VS_END + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL + 1);
    localparam int unsigned VW       = $clog2(V_TOTAL + 1);
    localparam int unsigned SW       = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned PIPE     = BRAM_LATENCY + 1;
    localparam int unsigned AW       = FBUF_ADDR_WIDTH;
    localparam logic        SYNC_OFF = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [HW-1:0]   h_cnt, h_nxt;
    logic [VW-1:0]   v_cnt, v_nxt;
    logic [SW-1:0]   x_sub, x_sub_nxt, y_sub, y_sub_nxt;
    logic [AW-1:0]   line_base, line_base_nxt, addr_q, addr_nxt;
    logic            h_end, v_end, x_wrap;
    logic            active0, active_nxt, hsync0, vsync0, fstart0;
    logic [PIPE-1:0] de_p, hs_p, vs_p, fs_p;
    logic [PIPE-2:0] busy_p;

    function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3],
                d[1:0], d[1:0], d[1:0], d[1:0]};
    endfunction

    always_comb begin
        h_end   = (h_cnt == HW'(H_TOTAL - 1));
        v_end   = (v_cnt == VW'(V_TOTAL - 1));
        h_nxt   = h_end ? '0 : h_cnt + 1'b1;
        v_nxt   = v_cnt;
        if (h_end) begin
            v_nxt = v_end ? '0 : v_cnt + 1'b1;
        end

        active0    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        active_nxt = (h_nxt < HW'(H_ACTIVE)) && (v_nxt < VW'(V_ACTIVE));
        hsync0     = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
        vsync0     = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
        fstart0    = (h_cnt == '0) && (v_cnt == '0);

        x_wrap    = (x_sub == SW'(SCALE - 1));
        x_sub_nxt = x_sub;
        if (active0) begin
            x_sub_nxt = x_wrap ? '0 : x_sub + 1'b1;
        end

        // Line base only moves after the last replica of a source line; the final
        // line never advances, so the address stays inside the framebuffer.
        y_sub_nxt     = y_sub;
        line_base_nxt = line_base;
        if (active0 && (h_cnt == HW'(H_ACTIVE - 1))) begin
            if (y_sub == SW'(SCALE - 1)) begin
                y_sub_nxt = '0;
                if (v_cnt != VW'(V_ACTIVE - 1)) begin
                    line_base_nxt = line_base + AW'(FRAME_WIDTH_SCALED);
                end
            end else begin
                y_sub_nxt = y_sub + 1'b1;
            end
        end
        if (h_end && v_end) begin
            y_sub_nxt     = '0;
            line_base_nxt = '0;
        end

        // Address register tracks the pixel at the current counter position, so
        // it only changes when the next position is active and holds in blanking.
        addr_nxt = addr_q;
        if (active_nxt) begin
            if (h_nxt == '0) begin
                addr_nxt = line_base_nxt;
            end else if (x_wrap) begin
                addr_nxt = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            x_sub     <= '0;
            y_sub     <= '0;
            line_base <= '0;
            addr_q    <= '0;
            de_p      <= '0;
            hs_p      <= '0;
            vs_p      <= '0;
            fs_p      <= '0;
            busy_p    <= '0;
            vid_rgb   <= '0;
        end else begin
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            x_sub     <= x_sub_nxt;
            y_sub     <= y_sub_nxt;
            line_base <= line_base_nxt;
            addr_q    <= addr_nxt;
            de_p      <= {de_p[PIPE-2:0], active0};
            hs_p      <= {hs_p[PIPE-2:0], hsync0};
            vs_p      <= {vs_p[PIPE-2:0], vsync0};
            fs_p      <= {fs_p[PIPE-2:0], fstart0};
            busy_p[0] <= fbuf_rst_busy;
            for (int unsigned i = 1; i < PIPE - 1; i++) begin
                busy_p[i] <= busy_p[i-1];
            end
            vid_rgb <= (de_p[PIPE-2] && !busy_p[PIPE-2]) ? expand_rgb332(fbuf_rdata[7:0]) : '0;
        end
    end

    assign fbuf_en_rd  = rst_n && active0 && !fbuf_rst_busy;
    assign fbuf_addr   = addr_q;
    assign vid_de      = de_p[PIPE-1];
    assign vid_hsync   = hs_p[PIPE-1] ^ SYNC_OFF;
    assign vid_vsync   = vs_p[PIPE-1] ^ SYNC_OFF;
    assign frame_start = fs_p[PIPE-1];

endmodule
